sad_match_scorer: RTL and testbench
===================================

Name: sad_match_scorer

Overview:
- Downstream consumer of the waveform matching engine (command #17 path).
- Receives the per-sample absolute-difference stream (|dx0-dx1|) for each phase shift and accumulates one saturating sum per phase.
- Emits each per-phase sum for memory write-back, and tracks the best (minimum) sum and its phase over the whole sweep.
- At sweep end, produces a registered match decision against a programmable threshold; this feeds the STAT/LED voice-valid indication (lstat 7/3).

Parameters:
- DW, 16, width of DIFF (memory data width).
- SUMW, 24, width of per-phase sum.
- PHW, 15, width of phase index.
- NSAMP, 8192, samples per phase.
- NPHASE, 1501, phases per sweep (phase 0..NPHASE-1).

Ports:
- CLK  in  1  system clock (125 MHz).
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse; begins a sweep.
- DIFF_VALID  in  1  DIFF beat valid; no backpressure.
- DIFF  in  DW  absolute difference for one sample.
- DIFF_LAST  in  1  qualifies the final beat of a phase (valid only with DIFF_VALID).
- THRESH  in  SUMW  match threshold; sampled at START.
- BUSY  out  1  high from the cycle after START until DONE.
- SUM_VALID  out  1  one-cycle strobe: SUM_OUT/SUM_PHASE valid.
- SUM_OUT  out  SUMW  completed per-phase sum.
- SUM_PHASE  out  PHW  phase index of SUM_OUT.
- BEST_SUM  out  SUMW  running minimum sum.
- BEST_PHASE  out  PHW  phase of BEST_SUM.
- DONE  out  1  one-cycle pulse at sweep end.
- MATCH  out  1  BEST_SUM < latched THRESH; valid from DONE until the next START.
- ERR  out  1  sticky protocol/overflow flag; cleared by START or RST.

Behaviour:
- Reset values: all outputs 0, except BEST_SUM = all-ones. State IDLE. Accumulator, sample counter and phase counter = 0.
- FSM states: IDLE, ACCUM, EVAL.
- IDLE:
  - START -> ACCUM.
  - Clears the accumulator, counters and ERR; sets BEST_SUM = all-ones and BEST_PHASE = 0; latches THRESH.
  - DIFF_VALID is ignored.
- ACCUM:
  - Each DIFF_VALID beat: acc = acc + DIFF, zero-extended, saturating at 2^SUMW-1. Saturation sets ERR.
  - Sample counter increments per beat.
  - On a DIFF_LAST beat at cycle t:
    - Final sum = acc + DIFF (saturating). At t+1: SUM_VALID=1, SUM_OUT = final sum, SUM_PHASE = phase.
    - If final sum < BEST_SUM (strict), then at t+1 BEST_SUM and BEST_PHASE update. Ties keep the earlier phase.
    - If the sample counter != NSAMP-1 at the DIFF_LAST beat, set ERR; the sum is still emitted.
    - The accumulator and sample counter clear; phase increments.
    - If phase == NPHASE-1, go to EVAL at t+1.
  - Overrun: a beat arriving with sample counter == NSAMP-1 and DIFF_LAST=0 sets ERR. That beat is still accumulated and the counter holds.
  - A DIFF_VALID beat in the cycle immediately after DIFF_LAST belongs to the next phase. Zero-bubble streaming is required.
- EVAL (one cycle, at t+1):
  - At t+2: DONE=1, MATCH = (BEST_SUM < THRESH_latched), BUSY=0, state -> IDLE.
  - Any DIFF_VALID in EVAL sets ERR and is dropped.
- START while BUSY is ignored; the sweep continues.
- RST at any time: immediate return to reset values on the next edge. Partial sums are discarded and no DONE is issued.
- All outputs are registered; there are no combinational input-to-output paths.
- Arithmetic is unsigned throughout; the comparator width is SUMW.

Decomposition:
- Shared package (coinc_pkg) holds:
  - constants: SUMW, PHW, NSAMP_DEFAULT=8192, NPHASE_DEFAULT=1501, REF_OFFSET=8192, SUM_BASE=16384;
  - the FSM state enum {IDLE, ACCUM, EVAL}.
- One sub-module is natural: sat_accum, a saturating SUMW adder with clear and an overflow flag, reused for the accumulator and final-sum path.

Test Plan:
- Bench parameters: NSAMP=4, NPHASE=3. START with THRESH=100. DIFF per phase: {5,5,5,5}, {1,2,3,4}, {10,10,10,10}, each with LAST on the 4th beat.
  -> SUM_VALID strobes (20,0), (10,1), (40,2); DONE; BEST_SUM=10, BEST_PHASE=1; MATCH=1; ERR=0.
- Same stimulus with THRESH=10 -> MATCH=0 (strict compare). Phase sums equal to 10 at phases 0 and 1 -> BEST_PHASE=0 (tie keeps earlier).
- SUMW=8, DIFF={200,100,1,1} -> SUM_OUT=255, ERR=1.
- DIFF_LAST on the 3rd beat -> ERR=1, sum emitted. A 5th beat without LAST -> ERR=1.
- RST asserted mid-phase 1 -> next cycle BUSY=0, BEST_SUM=all-ones, no DONE. A fresh START then completes normally.
- START pulsed during ACCUM -> ignored, phase count unaffected. Back-to-back beats across a phase boundary with no bubble -> sums exact.

Source files
------------

// File: rtl/coinc_pkg.sv
// rtl/coinc_pkg.sv - shared constants and FSM state type for the SAD match scorer
package coinc_pkg;
   localparam int SUMW           = 24;
   localparam int PHW            = 15;
   localparam int NSAMP_DEFAULT  = 8192;
   localparam int NPHASE_DEFAULT = 1501;
   localparam int REF_OFFSET     = 8192;
   localparam int SUM_BASE       = 16384;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EVAL  = 2'd2
   } state_e;
endpackage

// File: rtl/sat_accum.sv
// rtl/sat_accum.sv - saturating SUMW adder with clear and overflow flag
module sat_accum #(
   parameter int SUMW = 24,
   parameter int DW   = 16
) (
   input  logic            clr,
   input  logic [SUMW-1:0] base,
   input  logic [DW-1:0]   addend,
   output logic [SUMW-1:0] sum,
   output logic            ovf
);
   // one guard bit above the wider operand catches every carry out of SUMW
   localparam int XW = ((SUMW > DW) ? SUMW : DW) + 1;

   logic [XW-1:0] ext;
   logic [XW-1:0] lim;

   always_comb begin
      ext = (clr ? '0 : XW'(base)) + XW'(addend);
      lim = XW'({SUMW{1'b1}});
      ovf = (ext > lim);
      sum = ovf ? {SUMW{1'b1}} : ext[SUMW-1:0];
   end
endmodule

// File: rtl/sad_match_scorer.sv
// rtl/sad_match_scorer.sv - per-phase SAD accumulation, best-phase tracking and match decision
module sad_match_scorer #(
   parameter int DW     = 16,
   parameter int SUMW   = coinc_pkg::SUMW,
   parameter int PHW    = coinc_pkg::PHW,
   parameter int NSAMP  = coinc_pkg::NSAMP_DEFAULT,
   parameter int NPHASE = coinc_pkg::NPHASE_DEFAULT
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic            DIFF_VALID,
   input  logic [DW-1:0]   DIFF,
   input  logic            DIFF_LAST,
   input  logic [SUMW-1:0] THRESH,
   output logic            BUSY,
   output logic            SUM_VALID,
   output logic [SUMW-1:0] SUM_OUT,
   output logic [PHW-1:0]  SUM_PHASE,
   output logic [SUMW-1:0] BEST_SUM,
   output logic [PHW-1:0]  BEST_PHASE,
   output logic            DONE,
   output logic            MATCH,
   output logic            ERR
);
   import coinc_pkg::*;

   localparam int SCW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
   localparam logic [SCW-1:0] SAMP_LAST  = SCW'(NSAMP - 1);
   localparam logic [PHW-1:0] PHASE_LAST = PHW'(NPHASE - 1);

   state_e          state;
   logic [SUMW-1:0] acc;
   logic [SCW-1:0]  samp_cnt;
   logic [PHW-1:0]  phase;
   logic [SUMW-1:0] thresh_q;
   logic [SUMW-1:0] add_sum;
   logic            add_ovf;

   // the same adder result serves both the running total and the final phase sum
   sat_accum #(.SUMW(SUMW), .DW(DW)) u_sat_accum (
      .clr    (state != ACCUM),
      .base   (acc),
      .addend (DIFF),
      .sum    (add_sum),
      .ovf    (add_ovf)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         acc        <= '0;
         samp_cnt   <= '0;
         phase      <= '0;
         thresh_q   <= '0;
         BUSY       <= 1'b0;
         SUM_VALID  <= 1'b0;
         SUM_OUT    <= '0;
         SUM_PHASE  <= '0;
         BEST_SUM   <= '1;
         BEST_PHASE <= '0;
         DONE       <= 1'b0;
         MATCH      <= 1'b0;
         ERR        <= 1'b0;
      end else begin
         SUM_VALID <= 1'b0;
         DONE      <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  state      <= ACCUM;
                  acc        <= '0;
                  samp_cnt   <= '0;
                  phase      <= '0;
                  thresh_q   <= THRESH;
                  BUSY       <= 1'b1;
                  BEST_SUM   <= '1;
                  BEST_PHASE <= '0;
                  MATCH      <= 1'b0;
                  ERR        <= 1'b0;
               end
            end
            ACCUM: begin
               if (DIFF_VALID) begin
                  if (add_ovf) ERR <= 1'b1;
                  if (DIFF_LAST) begin
                     SUM_VALID <= 1'b1;
                     SUM_OUT   <= add_sum;
                     SUM_PHASE <= phase;
                     // strict compare so a tie keeps the earlier phase
                     if (add_sum < BEST_SUM) begin
                        BEST_SUM   <= add_sum;
                        BEST_PHASE <= phase;
                     end
                     if (samp_cnt != SAMP_LAST) ERR <= 1'b1;
                     acc      <= '0;
                     samp_cnt <= '0;
                     phase    <= phase + 1'b1;
                     if (phase == PHASE_LAST) state <= EVAL;
                  end else begin
                     acc <= add_sum;
                     // overrun: keep accumulating but hold the counter at its last value
                     if (samp_cnt == SAMP_LAST) ERR <= 1'b1;
                     else samp_cnt <= samp_cnt + 1'b1;
                  end
               end
            end
            EVAL: begin
               if (DIFF_VALID) ERR <= 1'b1;
               DONE  <= 1'b1;
               MATCH <= (BEST_SUM < thresh_q);
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sad_match_scorer.sv
// tb/tb_sad_match_scorer.sv - directed self-checking bench for sad_match_scorer
module tb_sad_match_scorer;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0, DIFF_VALID = 1'b0, DIFF_LAST = 1'b0;
   logic [15:0] DIFF = '0;
   logic [23:0] THRESH = '0;
   logic        BUSY, SUM_VALID, DONE, MATCH, ERR;
   logic [23:0] SUM_OUT, BEST_SUM;
   logic [14:0] SUM_PHASE, BEST_PHASE;

   logic        START8 = 1'b0, DIFF_VALID8 = 1'b0, DIFF_LAST8 = 1'b0;
   logic [15:0] DIFF8 = '0;
   logic [7:0]  THRESH8 = '0;
   logic        BUSY8, SUM_VALID8, DONE8, MATCH8, ERR8;
   logic [7:0]  SUM_OUT8, BEST_SUM8;
   logic [14:0] SUM_PHASE8, BEST_PHASE8;

   int checks = 0;
   int errors = 0;
   logic [31:0] got_sum[$];
   logic [31:0] got_ph[$];

   typedef struct {
      int thresh;
      int d[12];
      int es[3];
      int eb;
      int ep;
      int em;
   } vec_t;
   vec_t vecs[4];

   always #4 CLK = ~CLK;

   sad_match_scorer #(.DW(16), .SUMW(24), .PHW(15), .NSAMP(4), .NPHASE(3)) dut (
      .CLK(CLK), .RST(RST), .START(START), .DIFF_VALID(DIFF_VALID), .DIFF(DIFF),
      .DIFF_LAST(DIFF_LAST), .THRESH(THRESH), .BUSY(BUSY), .SUM_VALID(SUM_VALID),
      .SUM_OUT(SUM_OUT), .SUM_PHASE(SUM_PHASE), .BEST_SUM(BEST_SUM),
      .BEST_PHASE(BEST_PHASE), .DONE(DONE), .MATCH(MATCH), .ERR(ERR)
   );

   sad_match_scorer #(.DW(16), .SUMW(8), .PHW(15), .NSAMP(4), .NPHASE(1)) dut8 (
      .CLK(CLK), .RST(RST), .START(START8), .DIFF_VALID(DIFF_VALID8), .DIFF(DIFF8),
      .DIFF_LAST(DIFF_LAST8), .THRESH(THRESH8), .BUSY(BUSY8), .SUM_VALID(SUM_VALID8),
      .SUM_OUT(SUM_OUT8), .SUM_PHASE(SUM_PHASE8), .BEST_SUM(BEST_SUM8),
      .BEST_PHASE(BEST_PHASE8), .DONE(DONE8), .MATCH(MATCH8), .ERR(ERR8)
   );

   always @(negedge CLK) begin
      if (SUM_VALID) begin
         got_sum.push_back(32'(SUM_OUT));
         got_ph.push_back(32'(SUM_PHASE));
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start_sweep(input int t);
      START = 1'b1;
      THRESH = 24'(t);
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic beat(input int d, input bit last);
      DIFF = 16'(d);
      DIFF_VALID = 1'b1;
      DIFF_LAST = last;
      @(posedge CLK); #1;
   endtask

   task automatic stop_beats();
      DIFF_VALID = 1'b0;
      DIFF_LAST = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (DONE !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check({name, "_done"}, 32'(DONE), 32'd1);
   endtask

   task automatic run_sweep(input int idx, input bit start_mid);
      int n;
      got_sum.delete();
      got_ph.delete();
      start_sweep(vecs[idx].thresh);
      check("busy_after_start", 32'(BUSY), 32'd1);
      for (int p = 0; p < 3; p++) begin
         for (int s = 0; s < 4; s++) begin
            if (start_mid && p == 1 && s == 1) begin
               START = 1'b1;
               THRESH = 24'd0;
            end
            beat(vecs[idx].d[p*4+s], s == 3);
            START = 1'b0;
         end
      end
      stop_beats();
      wait_done($sformatf("v%0d", idx));
      n = got_sum.size();
      check($sformatf("v%0d_nsums", idx), 32'(n), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("v%0d_sum%0d", idx, i), (i < n) ? got_sum[i] : 32'hffffffff,
               32'(vecs[idx].es[i]));
         check($sformatf("v%0d_ph%0d", idx, i), (i < n) ? got_ph[i] : 32'hffffffff, 32'(i));
      end
      check($sformatf("v%0d_best", idx), 32'(BEST_SUM), 32'(vecs[idx].eb));
      check($sformatf("v%0d_bestph", idx), 32'(BEST_PHASE), 32'(vecs[idx].ep));
      check($sformatf("v%0d_match", idx), 32'(MATCH), 32'(vecs[idx].em));
      check($sformatf("v%0d_err", idx), 32'(ERR), 32'd0);
      check($sformatf("v%0d_busy_end", idx), 32'(BUSY), 32'd0);
   endtask

   initial begin
      int ndone;
      vecs[0].thresh = 100; vecs[0].d = '{5,5,5,5, 1,2,3,4, 10,10,10,10};
      vecs[0].es = '{20,10,40}; vecs[0].eb = 10; vecs[0].ep = 1; vecs[0].em = 1;
      vecs[1].thresh = 10;  vecs[1].d = '{5,5,5,5, 1,2,3,4, 10,10,10,10};
      vecs[1].es = '{20,10,40}; vecs[1].eb = 10; vecs[1].ep = 1; vecs[1].em = 0;
      vecs[2].thresh = 11;  vecs[2].d = '{1,2,3,4, 4,3,2,1, 0,0,0,50};
      vecs[2].es = '{10,10,50}; vecs[2].eb = 10; vecs[2].ep = 0; vecs[2].em = 1;
      vecs[3].thresh = 0;   vecs[3].d = '{0,0,0,0, 0,0,0,0, 0,0,0,0};
      vecs[3].es = '{0,0,0};    vecs[3].eb = 0;  vecs[3].ep = 0; vecs[3].em = 0;

      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_sum_valid", 32'(SUM_VALID), 32'd0);
      check("rst_best_sum", 32'(BEST_SUM), 32'hffffff);
      check("rst_best_phase", 32'(BEST_PHASE), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_match", 32'(MATCH), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);

      for (int v = 0; v < 4; v++) run_sweep(v, 1'b0);

      // saturation on the narrow-sum instance
      START8 = 1'b1; THRESH8 = 8'd100;
      @(posedge CLK); #1 START8 = 1'b0;
      DIFF_VALID8 = 1'b1;
      DIFF8 = 16'd200; DIFF_LAST8 = 1'b0; @(posedge CLK); #1;
      DIFF8 = 16'd100; @(posedge CLK); #1;
      DIFF8 = 16'd1;   @(posedge CLK); #1;
      DIFF8 = 16'd1;   DIFF_LAST8 = 1'b1; @(posedge CLK); #1;
      DIFF_VALID8 = 1'b0; DIFF_LAST8 = 1'b0;
      check("sat_valid", 32'(SUM_VALID8), 32'd1);
      check("sat_sum", 32'(SUM_OUT8), 32'd255);
      check("sat_err", 32'(ERR8), 32'd1);
      @(posedge CLK); #1;
      check("sat_done", 32'(DONE8), 32'd1);

      // short phase: LAST on the third beat
      start_sweep(100);
      beat(1, 0); beat(1, 0); beat(1, 1);
      stop_beats();
      check("short_valid", 32'(SUM_VALID), 32'd1);
      check("short_sum", 32'(SUM_OUT), 32'd3);
      check("short_err", 32'(ERR), 32'd1);
      for (int p = 0; p < 2; p++) begin
         beat(2, 0); beat(2, 0); beat(2, 0); beat(2, 1);
      end
      stop_beats();
      wait_done("short");
      check("short_err_sticky", 32'(ERR), 32'd1);

      // overrun: fifth beat of a phase, START clears ERR
      @(posedge CLK); #1;
      start_sweep(100);
      check("start_clears_err", 32'(ERR), 32'd0);
      beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 0);
      check("overrun_err", 32'(ERR), 32'd1);
      beat(1, 1);
      stop_beats();
      check("overrun_sum", 32'(SUM_OUT), 32'd5);
      for (int p = 0; p < 2; p++) begin
         beat(3, 0); beat(3, 0); beat(3, 0); beat(3, 1);
      end
      stop_beats();
      wait_done("overrun");

      // reset in the middle of phase 1
      @(posedge CLK); #1;
      start_sweep(100);
      beat(4, 0); beat(4, 0); beat(4, 0); beat(4, 1);
      beat(1, 0); beat(1, 0);
      stop_beats();
      RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      check("mid_rst_busy", 32'(BUSY), 32'd0);
      check("mid_rst_best", 32'(BEST_SUM), 32'hffffff);
      check("mid_rst_best_ph", 32'(BEST_PHASE), 32'd0);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) ndone++;
      end
      check("mid_rst_no_done", 32'(ndone), 32'd0);
      @(posedge CLK); #1;

      // fresh sweep with a START pulse landing in ACCUM
      run_sweep(0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no summary expected summary");
      $fatal(1, "timeout");
   end
endmodule
